misr_sig: RTL and testbench
===========================

Name: misr_sig

Overview:
- Multiple-input signature register (MISR): the response-compaction end of the prpg pattern flow.
- Where prpg's LFSR expands a seed into a pattern stream, misr_sig folds an incoming response stream into a WIDTH-bit signature.
- After a programmed number of beats it compares the signature against a golden value.
- Sits beside prpg in top and is driven by the device-under-test responses or by prpg data memory readback.

Parameters:
- WIDTH, 8, signature/data width.
- TAPS, 8'hB8, reset value of the feedback tap register.
- CNT_W, 8, width of the beat-length counter.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- seed_en  input  1  load seed into signature (IDLE/DONE only).
- seed  input  WIDTH  seed value.
- tap_en  input  1  load taps_in into tap register (IDLE/DONE only).
- taps_in  input  WIDTH  feedback polynomial.
- start  input  1  begin compaction run.
- len  input  CNT_W  number of beats to compact; sampled on start.
- data_valid  input  1  response beat present this cycle.
- data_in  input  WIDTH  response beat.
- golden  input  WIDTH  expected signature; sampled at end of run.
- abort  input  1  cancel run (present only with SIG_ABORT_EN).
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  signature == golden at end of run; valid while done.
- signature  output  WIDTH  current signature register.
- count  output  CNT_W  beats remaining.

Behaviour:
- Reset (reset==0, async): state=IDLE, signature=0, taps=TAPS, count=0, busy=0, done=0, pass=0.
- Update rule, applied on each accepted beat:
  - sh = signature<<1 (WIDTH bits).
  - If signature[WIDTH-1], sh ^= taps.
  - signature_next = sh ^ data_in.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - tap_en writes taps.
  - seed_en writes signature=seed.
  - If both are asserted, both writes occur.
  - start with len!=0 -> RUN, count=len.
  - start with len==0 -> DONE next cycle, signature unchanged, pass=(signature==golden).
- RUN:
  - busy=1.
  - data_valid=1 -> apply update, count--. data_valid=0 -> hold.
  - seed_en, tap_en and start are ignored.
  - On the beat where count==1: state->DONE, pass=(signature_next==golden), registered at the same edge.
  - Latency: done and pass are visible the cycle after the last beat.
- DONE:
  - done=1; signature, pass and count hold.
  - data_valid is ignored.
  - start -> behaves as start in IDLE (new run, same tap register; signature continues from current value unless reseeded).
  - seed_en -> IDLE with signature=seed.
  - start and seed_en together: seed loaded first, then the run begins from the new seed.
  - tap_en accepted, state unchanged.
- Count wrap: len==2^CNT_W-1 is legal. count never underflows; it reaches 0 only on entry to DONE.
- Reset mid-RUN: immediate return to reset values; the partial signature is lost.

Optional Feature:
- SIG_ABORT_EN defined:
  - Input abort exists.
  - abort=1 in RUN -> IDLE next edge, busy=0, done=0, pass=0, count=0; signature holds its partial value.
  - abort has priority over a same-cycle data_valid (that beat is not compacted).
  - abort in IDLE/DONE is ignored.
- SIG_ABORT_EN undefined: no abort port; a run ends only on count exhaustion or reset.

Test Plan:
- Seed 0x00, taps 0xB8, start len=1, data 0x5A valid, golden 0x5A -> cycle after beat: done=1, signature=0x5A, pass=1.
- Seed 0x80, len=1, data 0x00, golden 0x00 -> signature=0xB8 (feedback path), pass=0.
- Seed 0x01, len=3, data 0x00 with data_valid low 2 cycles between beats -> count 3,2,1 holds across gaps; signature 0x02,0x04,0x08; done exactly 1 cycle after third beat; busy high throughout.
- Seed 0x3C, start len=0, golden 0x3C -> done next cycle, busy never high, signature=0x3C, pass=1.
- RUN with len=4 after 2 beats: pulse reset low -> signature=0, taps=0xB8, state IDLE. Then tap_en 0x8E; seed_en/start during a fresh RUN are ignored (signature unaffected by seed).
- SIG_ABORT_EN: len=5, abort with data_valid on beat 3 -> next cycle busy=0, done=0, count=0, signature equals value after beat 2.

Source files
------------

// File: rtl/misr_sig.sv
// misr_sig: multiple-input signature register that folds a response stream into a
// WIDTH-bit signature and compares it with a golden value. Define SIG_ABORT_EN for the abort input.
module misr_sig #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_en,
    input  logic [WIDTH-1:0] seed,
    input  logic             tap_en,
    input  logic [WIDTH-1:0] taps_in,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] golden,
`ifdef SIG_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q,   sig_d;
    logic [WIDTH-1:0] taps_q,  taps_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pass_q,  pass_d;

    logic [WIDTH-1:0] beat_sig;
    logic [WIDTH-1:0] load_sig;
    logic             abort_req;
    logic             last_beat;

    // One compaction step: shift, fold the feedback polynomial in on MSB, xor the beat.
    function automatic logic [WIDTH-1:0] misr_step(
        input logic [WIDTH-1:0] sig,
        input logic [WIDTH-1:0] taps,
        input logic [WIDTH-1:0] beat
    );
        logic [WIDTH-1:0] sh;
        sh = {sig[WIDTH-2:0], 1'b0};
        if (sig[WIDTH-1]) begin
            sh = sh ^ taps;
        end
        return sh ^ beat;
    endfunction

`ifdef SIG_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign beat_sig  = misr_step(sig_q, taps_q, data_in);
    // A same-cycle seed is applied before a start, so a zero-length run compares the new seed.
    assign load_sig  = seed_en ? seed : sig_q;
    assign last_beat = (count_q == CNT_W'(1));

    // NOTE: every next-state variable gets its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        taps_d  = taps_q;
        count_d = count_q;
        pass_d  = pass_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (tap_en) begin
                    taps_d = taps_in;
                end
                if (seed_en) begin
                    sig_d   = seed;
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end
                if (start) begin
                    if (len != '0) begin
                        state_d = S_RUN;
                        count_d = len;
                        pass_d  = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        count_d = '0;
                        pass_d  = (load_sig == golden);
                    end
                end
            end

            S_RUN: begin
                if (abort_req) begin
                    // Partial signature is kept for debug; the run's bookkeeping is dropped.
                    state_d = S_IDLE;
                    count_d = '0;
                    pass_d  = 1'b0;
                end else if (data_valid) begin
                    sig_d   = beat_sig;
                    count_d = count_q - CNT_W'(1);
                    if (last_beat) begin
                        state_d = S_DONE;
                        pass_d  = (beat_sig == golden);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                count_d = '0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sig_q   <= '0;
            taps_q  <= TAPS;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            taps_q  <= taps_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign signature = sig_q;
    assign count     = count_q;

endmodule

// File: tb/tb_misr_sig.sv
// Self-checking bench for misr_sig: directed scenarios plus randomized runs against an
// arithmetic signature model. Abort scenario is compiled in when SIG_ABORT_EN is defined.
module tb_misr_sig;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       seed_en = 1'b0;
    logic [7:0] seed = '0;
    logic       tap_en = 1'b0;
    logic [7:0] taps_in = '0;
    logic       start = 1'b0;
    logic [7:0] len = '0;
    logic       data_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] golden = '0;
    logic       abort = 1'b0;
    logic       busy, done, pass;
    logic [7:0] signature, count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] m_taps;  // bench's own record of the tap register

    misr_sig dut (
        .clk(clk), .reset(reset), .seed_en(seed_en), .seed(seed), .tap_en(tap_en),
        .taps_in(taps_in), .start(start), .len(len), .data_valid(data_valid),
        .data_in(data_in), .golden(golden),
`ifdef SIG_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .pass(pass), .signature(signature), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Signature step with plain integer arithmetic: double, reduce by taps on overflow, add beat.
    function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [7:0] t,
                                            input logic [7:0] d);
        int v;
        v = int'(s) * 2;
        if (v >= 256) v = (v - 256) ^ int'(t);
        return 8'(v) ^ d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        seed_en = 0; tap_en = 0; start = 0; data_valid = 0; abort = 0;
    endtask

    // {busy,done,pass,count,signature} compared as one word
    task automatic expect_all(input string name, input logic b, input logic dn, input logic p,
                              input logic [7:0] c, input logic [7:0] s);
        logic [18:0] act, exp;
        act = {busy, done, pass, count, signature};
        exp = {b, dn, p, c, s};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got busy=%b done=%b pass=%b count=%0d sig=%h, want busy=%b done=%b pass=%b count=%0d sig=%h",
                     name, busy, done, pass, count, signature, b, dn, p, c, s);
        end
    endtask

    task automatic test_reset();
        reset = 0;
        #3;
        expect_all("reset_async", 0, 0, 0, 8'd0, 8'h00);
        tick();
        reset = 1;
        m_taps = 8'hB8;
        tick();
        expect_all("reset_idle", 0, 0, 0, 8'd0, 8'h00);
    endtask

    task automatic test_basic();
        seed_en = 1; seed = 8'h00; start = 1; len = 8'd1;
        tick(); idle_inputs();
        expect_all("basic_run", 1, 0, 0, 8'd1, 8'h00);
        data_valid = 1; data_in = 8'h5A; golden = 8'h5A;
        tick(); idle_inputs();
        expect_all("basic_done", 0, 1, 1, 8'd0, 8'h5A);
        tick();
        expect_all("basic_hold", 0, 1, 1, 8'd0, 8'h5A);
    endtask

    task automatic test_feedback();
        seed_en = 1; seed = 8'h80; start = 1; len = 8'd1;
        tick(); idle_inputs();
        expect_all("fb_run", 1, 0, 0, 8'd1, 8'h80);
        data_valid = 1; data_in = 8'h00; golden = 8'h00;
        tick(); idle_inputs();
        expect_all("fb_done", 0, 1, 0, 8'd0, 8'hB8);
    endtask

    task automatic test_gaps();
        logic [7:0] want [3];
        want = '{8'h02, 8'h04, 8'h08};
        seed_en = 1; seed = 8'h01; start = 1; len = 8'd3; golden = 8'h08;
        tick(); idle_inputs();
        expect_all("gap_start", 1, 0, 0, 8'd3, 8'h01);
        for (int b = 0; b < 3; b++) begin
            data_valid = 1; data_in = 8'h00;
            tick(); idle_inputs();
            if (b < 2) begin
                expect_all($sformatf("gap_beat%0d", b), 1, 0, 0, 8'(2 - b), want[b]);
                for (int g = 0; g < 2; g++) begin
                    tick();
                    expect_all($sformatf("gap_hold%0d_%0d", b, g), 1, 0, 0, 8'(2 - b), want[b]);
                end
            end else begin
                expect_all("gap_done", 0, 1, 1, 8'd0, want[b]);
            end
        end
    endtask

    task automatic test_len_zero();
        seed_en = 1; seed = 8'h3C;
        tick(); idle_inputs();
        expect_all("len0_seeded", 0, 0, 0, 8'd0, 8'h3C);
        start = 1; len = 8'd0; golden = 8'h3C;
        tick(); idle_inputs();
        expect_all("len0_done", 0, 1, 1, 8'd0, 8'h3C);
        // data in DONE must not be compacted
        data_valid = 1; data_in = 8'hFF;
        tick(); idle_inputs();
        expect_all("len0_ignore_data", 0, 1, 1, 8'd0, 8'h3C);
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s;
        seed_en = 1; seed = 8'h77; start = 1; len = 8'd4;
        tap_en = 1; taps_in = 8'h1D;
        tick(); idle_inputs();
        m_taps = 8'h1D;
        s = 8'h77;
        for (int b = 0; b < 2; b++) begin
            data_valid = 1; data_in = 8'($urandom);
            s = ref_step(s, m_taps, data_in);
            tick(); idle_inputs();
        end
        expect_all("mid_before_reset", 1, 0, 0, 8'd2, s);
        reset = 0;
        #1;
        expect_all("mid_reset_async", 0, 0, 0, 8'd0, 8'h00);
        #1;
        reset = 1;
        m_taps = 8'hB8;
        tick();
        expect_all("mid_after_reset", 0, 0, 0, 8'd0, 8'h00);
        // default taps must be back: 0x80 -> 0xB8
        seed_en = 1; seed = 8'h80; start = 1; len = 8'd1;
        tick(); idle_inputs();
        data_valid = 1; data_in = 8'h00; golden = 8'hB8;
        tick(); idle_inputs();
        expect_all("mid_taps_default", 0, 1, 1, 8'd0, 8'hB8);
        tap_en = 1; taps_in = 8'h8E;
        tick(); idle_inputs();
        m_taps = 8'h8E;
        expect_all("tap_in_done", 0, 1, 1, 8'd0, 8'hB8);
        seed_en = 1; seed = 8'h91; start = 1; len = 8'd3;
        tick(); idle_inputs();
        expect_all("fresh_run", 1, 0, 0, 8'd3, 8'h91);
        seed_en = 1; seed = 8'hFF; start = 1; len = 8'd9; tap_en = 1; taps_in = 8'h00;
        tick(); idle_inputs();
        expect_all("run_ignores_ctrl", 1, 0, 0, 8'd3, 8'h91);
        data_valid = 1; data_in = 8'h00;
        tick(); idle_inputs();
        expect_all("run_taps_kept", 1, 0, 0, 8'd2, ref_step(8'h91, 8'h8E, 8'h00));
        s = ref_step(8'h91, 8'h8E, 8'h00);
        for (int b = 0; b < 2; b++) begin
            data_valid = 1; data_in = 8'($urandom);
            s = ref_step(s, m_taps, data_in);
            golden = s;
            tick(); idle_inputs();
        end
        expect_all("run_finish", 0, 1, 1, 8'd0, s);
    endtask

    task automatic test_random();
        logic [7:0] s, l, c;
        logic       p;
        for (int r = 0; r < 40; r++) begin
            l = 8'($urandom_range(1, 20));
            s = 8'($urandom);
            seed_en = 1; seed = s; start = 1; len = l;
            if ($urandom_range(0, 1) == 1) begin
                tap_en = 1; taps_in = 8'($urandom);
                m_taps = taps_in;
            end
            tick(); idle_inputs();
            expect_all($sformatf("rnd%0d_start", r), 1, 0, 0, l, s);
            c = l;
            while (c != 0) begin
                if ($urandom_range(0, 2) != 0) begin
                    data_valid = 1; data_in = 8'($urandom);
                    s = ref_step(s, m_taps, data_in);
                    c = c - 1;
                    if (c == 0) golden = ($urandom_range(0, 1) == 1) ? s : 8'($urandom);
                end else begin
                    data_in = 8'($urandom);
                end
                tick(); idle_inputs();
                if (c != 0) expect_all($sformatf("rnd%0d_c%0d", r, c), 1, 0, 0, c, s);
            end
            p = (s == golden);
            expect_all($sformatf("rnd%0d_done", r), 0, 1, p, 8'd0, s);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] s;
        s = 8'hC3;
        seed_en = 1; seed = s; start = 1; len = 8'd255;
        tick(); idle_inputs();
        expect_all("wrap_start", 1, 0, 0, 8'd255, s);
        for (int b = 0; b < 255; b++) begin
            data_valid = 1; data_in = 8'($urandom);
            s = ref_step(s, m_taps, data_in);
            golden = s;
            tick(); idle_inputs();
            if (b == 0) expect_all("wrap_first", 1, 0, 0, 8'd254, s);
        end
        expect_all("wrap_done", 0, 1, 1, 8'd0, s);
    endtask

`ifdef SIG_ABORT_EN
    task automatic test_abort();
        logic [7:0] s;
        s = 8'h05;
        seed_en = 1; seed = s; start = 1; len = 8'd5;
        tick(); idle_inputs();
        for (int b = 0; b < 2; b++) begin
            data_valid = 1; data_in = 8'($urandom);
            s = ref_step(s, m_taps, data_in);
            tick(); idle_inputs();
        end
        abort = 1; data_valid = 1; data_in = 8'($urandom);
        tick(); idle_inputs();
        expect_all("abort_idle", 0, 0, 0, 8'd0, s);
        abort = 1; start = 1; len = 8'd2;
        tick(); idle_inputs();
        expect_all("abort_ignored_idle", 1, 0, 0, 8'd2, s);
        for (int b = 0; b < 2; b++) begin
            data_valid = 1; data_in = 8'($urandom);
            s = ref_step(s, m_taps, data_in);
            golden = s;
            tick(); idle_inputs();
        end
        abort = 1;
        tick(); idle_inputs();
        expect_all("abort_ignored_done", 0, 1, 1, 8'd0, s);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_feedback();
        test_gaps();
        test_len_zero();
        test_reset_mid_run();
        test_random();
        test_wrap();
`ifdef SIG_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
